ps2_init_sequencer: RTL and testbench

Host-side command sequencer for the PS/2 port. It brings a PS/2 mouse from power-up or hot-plug into streaming mode by issuing Reset (0xFF) and Enable Data Reporting (0xF4), checking each response byte, and retrying on errors or timeouts. After initialisation it forwards received bytes to the packet decoder. It sits between the PS/2 byte transceiver (frame TX/RX, open-drain pins) and the mouse packet decoder feeding the hex display, all in the `clk_pix` domain.

---
 rtl/ps2_init_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_init_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_init_sequencer.sv
// ps2_init_sequencer
// Host-side PS/2 mouse bring-up sequencer. Sends Reset (0xFF) and checks the
// 0xFA / 0xAA / 0x00 replies, then sends Enable Data Reporting (0xF4) and
// checks its 0xFA. Retries the whole sequence on errors or timeouts, and
// then forwards received bytes to the packet decoder.
//
// Ports:
//   clk_i, rstn_i             pixel clock, async active-low reset
//   start_i                   one-cycle start / restart request
//   tx_data_o, tx_valid_o     command byte to the transceiver (valid/ready)
//   tx_ready_i                transceiver can accept a byte
//   tx_done_i, tx_err_i       frame sent OK / frame failed (pulses)
//   rx_data_i, rx_valid_i     received byte and its strobe
//   stream_data_o/_valid_o    forwarded byte, one cycle after reception
//   ready_o, fail_o           streaming / retries exhausted (registered)
//   state_o                   current state encoding
module ps2_init_sequencer #(
  parameter int TIMEOUT_CYCLES    = 4_000_000,
  parameter int RESET_WAIT_CYCLES = 32_000_000,
  parameter int MAX_RETRY         = 3,
  parameter bit AUTO_START        = 1'b1,
  parameter bit HOTPLUG           = 1'b1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic       tx_done_i,
  input  logic       tx_err_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] stream_data_o,
  output logic       stream_valid_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_WAIT_RX = 3'd3,
    S_STREAM  = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  localparam int TW = $clog2(RESET_WAIT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_ACK   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_RESET = TW'(RESET_WAIT_CYCLES);
  localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic          step_q, step_d;      // 0: Reset command, 1: Enable Reporting
  logic [1:0]    idx_q, idx_d;        // index of the next expected reply byte
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          auto_q;              // high only until the first edge after reset
  logic          aa_seen_q;           // last streamed byte was 0xAA
  logic          ready_q, fail_q;
  logic          sv_q;
  logic [7:0]    sd_q;

  logic [7:0]    exp_byte;
  logic          last_byte;
  logic          do_retry;
  logic          hotplug_hit;

  // Expected reply for the current step and index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned; an unassigned path would infer a latch.
    exp_byte  = 8'hFA;
    last_byte = 1'b0;
    if (!step_q) begin
      case (idx_q)
        2'd0:    exp_byte = 8'hFA;
        2'd1:    exp_byte = 8'hAA;
        default: begin
          exp_byte  = 8'h00;
          last_byte = 1'b1;
        end
      endcase
    end else begin
      last_byte = 1'b1;
    end
  end

  assign hotplug_hit = HOTPLUG && (state_q == S_STREAM) && rx_valid_i &&
                       (rx_data_i == 8'h00) && aa_seen_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    do_retry = 1'b0;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (start_i || auto_q) begin
          state_d = S_SEND;
          step_d  = 1'b0;
        end
      end
      S_SEND: begin
        idx_d = '0;
        // tx_valid_o is high throughout SEND, so tx_ready_i completes the handshake.
        if (tx_ready_i) begin
          state_d = S_WAIT_TX;
          timer_d = T_ACK;
        end
      end
      S_WAIT_TX: begin
        // Error beats done; either event beats an expiring timer.
        if (tx_err_i)                 do_retry = 1'b1;
        else if (tx_done_i) begin
          state_d = S_WAIT_RX;
          timer_d = T_ACK;
        end
        else if (timer_q == '0)       do_retry = 1'b1;
        else                          timer_d = timer_q - TW'(1);
      end
      S_WAIT_RX: begin
        if (rx_valid_i) begin
          if (rx_data_i == exp_byte) begin
            if (last_byte) begin
              if (!step_q) begin
                state_d = S_SEND;
                step_d  = 1'b1;
              end else begin
                state_d = S_STREAM;
              end
            end else begin
              idx_d   = idx_q + 2'd1;
              // After the first 0xFA of Reset the device runs its self-test.
              timer_d = (idx_q == 2'd0) ? T_RESET : T_ACK;
            end
          end else if (rx_data_i == 8'hFE) begin
            // Resend request repeats the same step but still costs a retry.
            if (retry_q < R_MAX) begin
              retry_d = retry_q + RW'(1);
              state_d = S_SEND;
            end else begin
              state_d = S_FAIL;
            end
          end else begin
            do_retry = 1'b1;
          end
        end
        else if (timer_q == '0) do_retry = 1'b1;
        else                    timer_d = timer_q - TW'(1);
      end
      S_STREAM: begin
        if (start_i) begin
          state_d = S_SEND;
          step_d  = 1'b0;
          retry_d = '0;
        end else if (hotplug_hit) begin
          // A replugged mouse has already self-tested; only re-enable reporting.
          state_d = S_SEND;
          step_d  = 1'b1;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        if (start_i) begin
          state_d = S_SEND;
          step_d  = 1'b0;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_retry) begin
      if (retry_q < R_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = S_SEND;
        step_d  = 1'b0;
      end else begin
        state_d = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      step_q    <= 1'b0;
      idx_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      auto_q    <= AUTO_START;
      aa_seen_q <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      sv_q      <= 1'b0;
      sd_q      <= 8'h00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      auto_q  <= 1'b0;
      ready_q <= (state_d == S_STREAM);
      fail_q  <= (state_d == S_FAIL);
      sv_q    <= 1'b0;
      if (state_q == S_STREAM && rx_valid_i) begin
        sv_q      <= 1'b1;
        sd_q      <= rx_data_i;
        aa_seen_q <= (rx_data_i == 8'hAA);
      end else if (state_q != S_STREAM) begin
        aa_seen_q <= 1'b0;
      end
    end
  end

  // Decoded from the async-reset state register, so it drops at once on reset.
  assign tx_valid_o     = (state_q == S_SEND);
  assign tx_data_o      = (state_q != S_SEND) ? 8'h00 : (step_q ? 8'hF4 : 8'hFF);
  assign stream_valid_o = sv_q;
  assign stream_data_o  = sd_q;
  assign ready_o        = ready_q;
  assign fail_o         = fail_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// Self-checking bench for ps2_init_sequencer: a table of per-cycle vectors
// covering clean init, streaming and hot-plug, plus hand-written sequences
// for resend, mismatch, error priority, retry exhaustion and async reset.
module tb_ps2_init_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, tx_ready, tx_done, tx_err, rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data, stream_data;
  logic       tx_valid, stream_valid, ready, fail;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps2_init_sequencer #(
    .TIMEOUT_CYCLES   (100),
    .RESET_WAIT_CYCLES(300),
    .MAX_RETRY        (3),
    .AUTO_START       (1'b1),
    .HOTPLUG          (1'b1)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .start_i       (start),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .tx_done_i     (tx_done),
    .tx_err_i      (tx_err),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .stream_data_o (stream_data),
    .stream_valid_o(stream_valid),
    .ready_o       (ready),
    .fail_o        (fail),
    .state_o       (state)
  );

  typedef struct {
    logic       s, r, d, e, rv;
    logic [7:0] rd;
    logic [2:0] st;
    logic       txv;
    logic [7:0] txd;
    logic       sv;
    logic [7:0] sd;
    logic       rdy, fl;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic s, r, d, e, rv, input logic [7:0] rd,
                              input logic [2:0] st, input logic txv,
                              input logic [7:0] txd, input logic sv,
                              input logic [7:0] sd, input logic rdy, fl);
    vec_t v;
    v.s = s; v.r = r; v.d = d; v.e = e; v.rv = rv; v.rd = rd;
    v.st = st; v.txv = txv; v.txd = txd; v.sv = sv; v.sd = sd;
    v.rdy = rdy; v.fl = fl;
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {state, tx_valid, tx_data, stream_valid, stream_data, ready, fail};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the DUT take the edge, sample 1 ns later.
  task automatic cyc(input logic s, r, d, e, rv, input logic [7:0] rd);
    start = s; tx_ready = r; tx_done = d; tx_err = e; rx_valid = rv; rx_data = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    start = 0; tx_ready = 0; tx_done = 0; tx_err = 0; rx_valid = 0; rx_data = 8'h00;
    #2;
    rstn = 1'b1;
  endtask

  // From a fresh reset, run Reset-command exchange up to SEND 0xF4.
  task automatic run_to_f4();
    idle();                          // auto-start -> SEND 0xFF
    cyc(0, 1, 0, 0, 0, 8'h00);       // accepted
    cyc(0, 0, 1, 0, 0, 8'h00);       // line ACK
    cyc(0, 0, 0, 0, 1, 8'hFA);
    cyc(0, 0, 0, 0, 1, 8'hAA);
    cyc(0, 0, 0, 0, 1, 8'h00);       // -> SEND 0xF4
  endtask

  initial begin
    int sends;
    int n;

    // st txv txd sv sd rdy fail after each edge
    vecs[0]  = mk(0,0,0,0,0,8'h00, 3'd1,1,8'hFF, 0,8'h00, 0,0);
    vecs[1]  = mk(0,1,0,0,0,8'h00, 3'd2,0,8'h00, 0,8'h00, 0,0);
    vecs[2]  = mk(0,0,1,0,0,8'h00, 3'd3,0,8'h00, 0,8'h00, 0,0);
    vecs[3]  = mk(0,0,0,0,1,8'hFA, 3'd3,0,8'h00, 0,8'h00, 0,0);
    vecs[4]  = mk(0,0,0,0,1,8'hAA, 3'd3,0,8'h00, 0,8'h00, 0,0);
    vecs[5]  = mk(0,0,0,0,1,8'h00, 3'd1,1,8'hF4, 0,8'h00, 0,0);
    vecs[6]  = mk(0,0,0,0,0,8'h00, 3'd1,1,8'hF4, 0,8'h00, 0,0);
    vecs[7]  = mk(0,1,0,0,0,8'h00, 3'd2,0,8'h00, 0,8'h00, 0,0);
    vecs[8]  = mk(0,0,1,0,0,8'h00, 3'd3,0,8'h00, 0,8'h00, 0,0);
    vecs[9]  = mk(0,0,0,0,1,8'hFA, 3'd4,0,8'h00, 0,8'h00, 1,0);
    vecs[10] = mk(0,0,0,0,1,8'h08, 3'd4,0,8'h00, 1,8'h08, 1,0);
    vecs[11] = mk(0,0,0,0,1,8'h10, 3'd4,0,8'h00, 1,8'h10, 1,0);
    vecs[12] = mk(0,0,0,0,1,8'hF0, 3'd4,0,8'h00, 1,8'hF0, 1,0);
    vecs[13] = mk(0,0,0,0,0,8'h00, 3'd4,0,8'h00, 0,8'hF0, 1,0);
    vecs[14] = mk(0,0,0,0,1,8'hAA, 3'd4,0,8'h00, 1,8'hAA, 1,0);
    vecs[15] = mk(0,0,0,0,1,8'h00, 3'd1,1,8'hF4, 1,8'h00, 0,0);
    vecs[16] = mk(0,1,0,0,0,8'h00, 3'd2,0,8'h00, 0,8'h00, 0,0);
    vecs[17] = mk(0,0,1,0,0,8'h00, 3'd3,0,8'h00, 0,8'h00, 0,0);
    vecs[18] = mk(0,0,0,0,1,8'hFA, 3'd4,0,8'h00, 0,8'h00, 1,0);
    vecs[19] = mk(0,0,0,0,1,8'hAA, 3'd4,0,8'h00, 1,8'hAA, 1,0);
    vecs[20] = mk(0,0,0,0,1,8'h01, 3'd4,0,8'h00, 1,8'h01, 1,0);
    vecs[21] = mk(0,0,0,0,1,8'h00, 3'd4,0,8'h00, 1,8'h00, 1,0);
    vecs[22] = mk(1,0,0,0,0,8'h00, 3'd1,1,8'hFF, 0,8'h00, 0,0);

    rstn = 1'b0;
    start = 0; tx_ready = 0; tx_done = 0; tx_err = 0; rx_valid = 0; rx_data = 8'h00;
    #23;
    check("reset_outputs", 32'(outs()), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cyc(vecs[i].s, vecs[i].r, vecs[i].d, vecs[i].e, vecs[i].rv, vecs[i].rd);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].st, vecs[i].txv, vecs[i].txd, vecs[i].sv, vecs[i].sd,
                 vecs[i].rdy, vecs[i].fl}));
    end

    // Resend: 0xFE in reply to 0xF4 re-sends 0xF4, then init completes.
    do_reset();
    run_to_f4();
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'hFE);
    check("resend_state", 32'(state), 32'd1);
    check("resend_data", 32'(tx_data), 32'hF4);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'hFA);
    check("resend_ready", 32'({ready, fail, state}), 32'({1'b1, 1'b0, 3'd4}));

    // Mismatch: 0x55 instead of 0xAA restarts with 0xFF.
    do_reset();
    idle();
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'hFA);
    cyc(0, 0, 0, 0, 1, 8'h55);
    check("mismatch_restart", 32'({state, tx_valid, tx_data}), 32'({3'd1, 1'b1, 8'hFF}));

    // Done and error together: error wins, so retry instead of WAIT_RX.
    do_reset();
    idle();
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 1, 0, 8'h00);
    check("err_priority", 32'({state, tx_data}), 32'({3'd1, 8'hFF}));

    // Exhaustion: accept every 0xFF, never complete; 4 sends then FAIL.
    do_reset();
    sends = 0;
    n = 0;
    while (!fail && n < 1000) begin
      if (tx_valid) begin
        if (tx_data == 8'hFF) sends++;
        cyc(0, 1, 0, 0, 0, 8'h00);
      end else begin
        idle();
      end
      n++;
    end
    check("exh_sends", 32'(sends), 32'd4);
    check("exh_fail", 32'({fail, ready, state}), 32'({1'b1, 1'b0, 3'd5}));
    idle();
    check("exh_hold", 32'({fail, state}), 32'({1'b1, 3'd5}));
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("exh_restart", 32'({fail, state, tx_valid, tx_data}),
          32'({1'b0, 3'd1, 1'b1, 8'hFF}));

    // Async reset while a command is on offer.
    do_reset();
    idle();
    check("pre_reset_txv", 32'(tx_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'd0);
    #3;
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
